// File: rtl/fifo_fwft_pkg.sv
// rtl/fifo_fwft_pkg.sv - shared constants, types and width helper for the FWFT read adapter
package fifo_fwft_pkg;

    localparam int RD_LAT_NO_OREG  = 1;
    localparam int RD_LAT_OREG     = 2;
    localparam int FWFT_DATA_WIDTH = 8;

    typedef logic [FWFT_DATA_WIDTH-1:0] data_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_fwft_skid_buf.sv
// rtl/fifo_fwft_skid_buf.sv - circular skid buffer with level counter and registered head word
module fifo_fwft_skid_buf
    import fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = FWFT_DATA_WIDTH,
    parameter int DEPTH      = 2,
    parameter int LVL_W      = cnt_width(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0]      level
);

    localparam int PTR_W = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic [LVL_W-1:0]      level_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_ptr_nxt = rd_en ? ptr_inc(rd_ptr) : rd_ptr;
        level_nxt  = level + LVL_W'(wr_en) - LVL_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            // Head must be valid in the same cycle level goes non-zero, so bypass the word being written.
            if (level_nxt != '0) begin
                rd_data <= (wr_en && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
            end
        end
    end

    overflow_chk : assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !rd_en && (level == LVL_W'(DEPTH))));

endmodule

// File: rtl/fifo_fwft_rd_adapter.sv
// rtl/fifo_fwft_rd_adapter.sv - FIFO read port to FWFT valid/ready stream; optional FWFT_WORD_CNT_EN adds word_cnt
module fifo_fwft_rd_adapter
    import fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = FWFT_DATA_WIDTH,
    parameter int RD_LATENCY = RD_LAT_NO_OREG,
    parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
    input  logic                                rd_clk,
    input  logic                                rd_rst_n,
    output logic                                fifo_rd_en,
    output logic                                fifo_rd_oce,
    input  logic                                fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0]               fifo_rd_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [DATA_WIDTH-1:0]               m_data,
    output logic [cnt_width(BUF_DEPTH+1)-1:0]   buf_level
`ifdef FWFT_WORD_CNT_EN
    ,
    output logic [31:0]                         word_cnt
`endif
);

    logic [RD_LATENCY-1:0] vpipe;
    logic                  pop;
    logic                  capture;
    int                    inflight;

    assign pop         = m_valid & m_ready;
    assign capture     = vpipe[RD_LATENCY-1];
    assign m_valid     = (buf_level != '0);
    assign fifo_rd_oce = 1'b1;

    // Credit check: buffered + in-flight words, less the one leaving now, must leave room for a new issue.
    always_comb begin
        inflight = 0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            inflight = inflight + int'(vpipe[k]);
        end
        fifo_rd_en = !fifo_rd_empty &&
                     ((int'(buf_level) + inflight - int'(pop)) < BUF_DEPTH);
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe <= (vpipe << 1) | RD_LATENCY'(fifo_rd_en);
        end
    end

    fifo_fwft_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .LVL_W      (cnt_width(BUF_DEPTH+1))
    ) u_skid_buf (
        .clk     (rd_clk),
        .rst_n   (rd_rst_n),
        .wr_en   (capture),
        .wr_data (fifo_rd_data),
        .rd_en   (pop),
        .rd_data (m_data),
        .level   (buf_level)
    );

`ifdef FWFT_WORD_CNT_EN
    logic [31:0] word_cnt_q;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            word_cnt_q <= '0;
        end else if (pop) begin
            word_cnt_q <= word_cnt_q + 32'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_fwft_rd_adapter.sv
// tb/tb_fifo_fwft_rd_adapter.sv - directed bench for both read latencies against a behavioural FIFO read port
module tb_fifo_fwft_rd_adapter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rd_en;
    logic [1:0] oce;
    logic [1:0] empty;
    logic [1:0] valid;
    logic [1:0] ready;
    logic [7:0] rdata [2];
    logic [7:0] mdata [2];
    logic [1:0] lvl   [2];
`ifdef FWFT_WORD_CNT_EN
    logic [31:0] wcnt [2];
`endif

    logic [7:0] mem [2][4096];
    logic [7:0] d1  [2];
    logic [7:0] d2  [2];
    int avail [2];
    int rp    [2];
    int exp_idx [2];
    int en_cnt [2], pop_cnt [2], first_en [2], last_en [2];
    int first_val [2], first_pop [2], last_pop [2];
    int vectors, miscompares, cyc;

    always #5 clk = ~clk;

    assign rdata[0] = d1[0];
    assign rdata[1] = d2[1];

    fifo_fwft_rd_adapter #(.DATA_WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(2)) u_dut0 (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(rd_en[0]), .fifo_rd_oce(oce[0]),
        .fifo_rd_empty(empty[0]), .fifo_rd_data(rdata[0]), .m_valid(valid[0]),
        .m_ready(ready[0]), .m_data(mdata[0]), .buf_level(lvl[0])
`ifdef FWFT_WORD_CNT_EN
        , .word_cnt(wcnt[0])
`endif
    );

    fifo_fwft_rd_adapter #(.DATA_WIDTH(8), .RD_LATENCY(2), .BUF_DEPTH(3)) u_dut1 (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(rd_en[1]), .fifo_rd_oce(oce[1]),
        .fifo_rd_empty(empty[1]), .fifo_rd_data(rdata[1]), .m_valid(valid[1]),
        .m_ready(ready[1]), .m_data(mdata[1]), .buf_level(lvl[1])
`ifdef FWFT_WORD_CNT_EN
        , .word_cnt(wcnt[1])
`endif
    );

    // FIFO read port: registered empty, one data register, plus an output register for instance 1.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                rp[i]    <= avail[i];
                empty[i] <= 1'b1;
                d1[i]    <= '0;
                d2[i]    <= '0;
            end else begin
                if (rd_en[i]) begin
                    d1[i] <= mem[i][rp[i]];
                    rp[i] <= rp[i] + 1;
                end
                d2[i]    <= d1[i];
                empty[i] <= (avail[i] == rp[i] + int'(rd_en[i]));
            end
        end
    end

    function automatic int dep(input int i);
        return i + 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic add_word(input int i, input logic [7:0] v);
        mem[i][avail[i]] = v;
        avail[i]++;
    endtask

    task automatic clear_stats;
        for (int i = 0; i < 2; i++) begin
            en_cnt[i] = 0; pop_cnt[i] = 0;
            first_en[i] = -1; last_en[i] = -1; first_val[i] = -1;
            first_pop[i] = -1; last_pop[i] = -1;
        end
    endtask

    // Sample mid-cycle, then return 1 time unit after the next rising edge.
    task automatic tick;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
                if (first_en[i] < 0) first_en[i] = cyc;
                last_en[i] = cyc;
                en_cnt[i]++;
            end
            chk("rd_en_while_empty", 32'(rd_en[i] & empty[i]), 32'd0);
            chk("level_bound", 32'(int'(lvl[i]) > dep(i)), 32'd0);
            if (valid[i]) begin
                if (first_val[i] < 0) first_val[i] = cyc;
                chk("m_data", 32'(mdata[i]), 32'(mem[i][exp_idx[i]]));
                if (ready[i]) begin
                    if (first_pop[i] < 0) first_pop[i] = cyc;
                    last_pop[i] = cyc;
                    pop_cnt[i]++;
                    exp_idx[i]++;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        int added;
        int n;
        vectors = 0; miscompares = 0; cyc = 0;
        ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            avail[i] = 0; exp_idx[i] = 0;
        end
        clear_stats();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_m_valid", 32'(valid[i]), 32'd0);
            chk("rst_rd_en", 32'(rd_en[i]), 32'd0);
            chk("rst_level", 32'(lvl[i]), 32'd0);
            chk("rst_m_data", 32'(mdata[i]), 32'd0);
        end
        chk("rd_oce", 32'(oce), 32'd3);
        rst_n = 1'b1;
        repeat (2) tick();

        // Stream with m_ready held high
        clear_stats();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++) add_word(i, (i == 1) ? 8'(8'h80 + k) : 8'(k));
        ready = 2'b11;
        repeat (24) tick();
        for (int i = 0; i < 2; i++) begin
            chk("stream_rd_en_cnt", 32'(en_cnt[i]), 32'd16);
            chk("stream_rd_en_run", 32'(last_en[i] - first_en[i]), 32'd15);
            chk("stream_latency", 32'(first_val[i] - first_en[i]), 32'(i + 2));
            chk("stream_pop_cnt", 32'(pop_cnt[i]), 32'd16);
            chk("stream_no_bubble", 32'(last_pop[i] - first_pop[i]), 32'd15);
        end

        // Back-pressure: credits stop issue at the buffer depth
        clear_stats();
        ready = 2'b00;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 10; k++) add_word(i, 8'(8'h20 + 3 * k + i));
        repeat (12) tick();
        for (int i = 0; i < 2; i++) begin
            chk("bp_rd_en_cnt", 32'(en_cnt[i]), 32'(dep(i)));
            chk("bp_level", 32'(lvl[i]), 32'(dep(i)));
            chk("bp_m_valid", 32'(valid[i]), 32'd1);
            chk("bp_head", 32'(mdata[i]), 32'(8'h20 + i));
        end
        ready = 2'b11;
        repeat (15) tick();
        for (int i = 0; i < 2; i++) begin
            chk("bp_pop_cnt", 32'(pop_cnt[i]), 32'd10);
            chk("bp_no_gap", 32'(last_pop[i] - first_pop[i]), 32'd9);
        end

        // Random ready and trickled FIFO fill
        clear_stats();
        added = 0;
        g = 0;
        while ((pop_cnt[0] < 2048 || pop_cnt[1] < 2048) && g < 20000) begin
            ready = 2'($urandom);
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                if (added < 2048) begin
                    for (int i = 0; i < 2; i++) add_word(i, 8'($urandom));
                    added++;
                end
            end
            tick();
            g++;
        end
        for (int i = 0; i < 2; i++) begin
            chk("rand_pop_cnt", 32'(pop_cnt[i]), 32'd2048);
            chk("rand_lossless", 32'(exp_idx[i]), 32'(avail[i]));
        end

        // Single word into an empty FIFO
        ready = 2'b11;
        repeat (4) tick();
        clear_stats();
        for (int i = 0; i < 2; i++) add_word(i, 8'(8'h5A + i));
        repeat (8) tick();
        for (int i = 0; i < 2; i++) begin
            chk("empty_rd_en_cnt", 32'(en_cnt[i]), 32'd1);
            chk("empty_pop_cnt", 32'(pop_cnt[i]), 32'd1);
            chk("empty_m_valid", 32'(valid[i]), 32'd0);
            chk("empty_rd_en", 32'(rd_en[i]), 32'd0);
        end

        // Asynchronous reset mid-stream
        ready = 2'b00;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 5; k++) add_word(i, 8'($urandom));
        g = 0;
        while (lvl[0] != 2'd2 && g < 20) begin
            tick();
            g++;
        end
        chk("pre_rst_level", 32'(lvl[0]), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_m_valid", 32'(valid[i]), 32'd0);
            chk("arst_level", 32'(lvl[i]), 32'd0);
            chk("arst_rd_en", 32'(rd_en[i]), 32'd0);
            chk("arst_m_data", 32'(mdata[i]), 32'd0);
            exp_idx[i] = avail[i];
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();

`ifdef FWFT_WORD_CNT_EN
        clear_stats();
        ready = 2'b11;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 300; k++) add_word(i, 8'(k));
        g = 0;
        while ((pop_cnt[0] < 300 || pop_cnt[1] < 300) && g < 1000) begin
            tick();
            g++;
        end
        chk("word_cnt_300_0", wcnt[0], 32'd300);
        chk("word_cnt_300_1", wcnt[1], 32'd300);
        repeat (4) tick();
        force u_dut0.word_cnt_q = 32'hFFFF_FFFF;
        force u_dut1.word_cnt_q = 32'hFFFF_FFFF;
        #1;
        release u_dut0.word_cnt_q;
        release u_dut1.word_cnt_q;
        for (int i = 0; i < 2; i++) add_word(i, 8'h77);
        repeat (8) tick();
        chk("word_cnt_wrap_0", wcnt[0], 32'd0);
        chk("word_cnt_wrap_1", wcnt[1], 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
